// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main sequencing FSM for the multicycle RV32I core.
// Rev 1.0 - fetch/decode/exec/mem/wb sequencing with illegal-opcode and bus-timeout traps.
`default_nettype none

module multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  i_type,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_OP, C_OPIMM, C_LOAD, C_STORE, C_BRANCH, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BAD
  } cls_t;

  localparam logic [CNT_W-1:0] c_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state, w_next;
  cls_t             r_cls, w_dec_cls;
  logic [2:0]       r_itype, w_dec_itype;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal, r_bus_err;
  logic             w_timeout, w_set_illegal, w_set_bus_err;
  logic             w_unused;

  assign w_unused  = ^{instr[31:15], instr[11:7]};
  assign illegal   = r_illegal;
  assign bus_err   = r_bus_err;
  // mem_ready on the limit cycle takes priority over the timeout.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_LIMIT) && !mem_ready;

  always_comb begin
    w_dec_cls   = C_BAD;
    w_dec_itype = 3'd7;
    case (instr[6:0])
      7'b0110011: begin w_dec_cls = C_OP;     w_dec_itype = 3'd7; end
      7'b0010011: begin w_dec_cls = C_OPIMM;  w_dec_itype = 3'd0; end
      7'b0000011: begin w_dec_cls = C_LOAD;   w_dec_itype = 3'd0; end
      7'b0100011: begin w_dec_cls = C_STORE;  w_dec_itype = 3'd1; end
      7'b1100011: begin w_dec_cls = C_BRANCH; w_dec_itype = 3'd2; end
      7'b0110111: begin w_dec_cls = C_LUI;    w_dec_itype = 3'd3; end
      7'b0010111: begin w_dec_cls = C_AUIPC;  w_dec_itype = 3'd3; end
      7'b1101111: begin w_dec_cls = C_JAL;    w_dec_itype = 3'd4; end
      7'b1100111: begin
        if (instr[14:12] == 3'b000) begin
          w_dec_cls   = C_JALR;
          w_dec_itype = 3'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next        = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'd0;
    i_type        = r_itype;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'd0;
    retire        = 1'b0;
    w_set_illegal = 1'b0;
    w_set_bus_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_type = 3'd7;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_DECODE: begin
        i_type = w_dec_itype;
        if (w_dec_cls == C_BAD) begin
          w_set_illegal = 1'b1;
          w_next        = S_TRAP;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_b_sel = !((r_cls == C_OP) || (r_cls == C_BRANCH));
        alu_a_sel = (r_cls == C_AUIPC);
        case (r_cls)
          C_BRANCH: begin
            pc_write = 1'b1;
            pc_src   = branch_taken ? 2'd1 : 2'd0;
            retire   = 1'b1;
            w_next   = S_FETCH;
          end
          C_LOAD, C_STORE: w_next = S_MEM;
          default:         w_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (r_cls == C_STORE);
        if (mem_ready) begin
          if (r_cls == C_LOAD) begin
            w_next = S_WB;
          end else begin
            pc_write = 1'b1;
            retire   = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_timeout) begin
          w_set_bus_err = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
        case (r_cls)
          C_LOAD:  wb_sel = 2'd1;
          C_JAL:   begin wb_sel = 2'd2; pc_src = 2'd1; end
          C_JALR:  begin wb_sel = 2'd2; pc_src = 2'd2; end
          C_LUI:   wb_sel = 2'd3;
          default: wb_sel = 2'd0;
        endcase
      end
      S_TRAP: ;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cls     <= C_OP;
      r_itype   <= 3'd7;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
      r_bus_err <= r_bus_err | w_set_bus_err;
      if (r_state == S_DECODE) begin
        r_cls   <= w_dec_cls;
        r_itype <= w_dec_itype;
      end
      if (mem_ready || (w_next != r_state)) begin
        r_cnt <= '0;
      end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle scoreboard bench for multicycle_ctrl.
// Rev 1.0 - expected per-cycle outputs are queued as stimulus is planned, then popped and compared.
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;

  localparam int TIMEOUT_CYCLES = 4;
  localparam int CNT_W          = 8;

  localparam int P_RESET = 0, P_IDLE = 1, P_FWAIT = 2, P_FETCH = 3, P_DEC = 4, P_EXEC = 5;
  localparam int P_MWAIT = 6, P_MEM = 7, P_WB = 8, P_TRAP = 9, P_RSTMID = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  i_type;
  logic        alu_a_sel, alu_b_sel, reg_write, retire, illegal, bus_err;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] i_type;
    logic       alu_a;
    logic       alu_b;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic       illegal;
    logic       bus_err;
  } outs_t;

  typedef struct packed {
    logic  mr;
    logic  bt;
    outs_t exp;
    outs_t msk;
    int    ph;
    int    idx;
  } step_t;

  outs_t      w_obs;
  step_t      q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_instr  = 0;
  logic [2:0] m_itype  = 3'd7;

  assign w_obs = {mem_req, mem_we, addr_sel, ir_write, pc_write, pc_src, i_type,
                  alu_a_sel, alu_b_sel, reg_write, wb_sel, retire, illegal, bus_err};

  multicycle_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .i_type(i_type), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire), .illegal(illegal),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  function automatic string pname(input int p);
    case (p)
      P_RESET: return "reset";   P_IDLE:  return "idle";   P_FWAIT: return "fetch_wait";
      P_FETCH: return "fetch";   P_DEC:   return "decode"; P_EXEC:  return "exec";
      P_MWAIT: return "mem_wait"; P_MEM:  return "mem";    P_WB:    return "wb";
      P_TRAP:  return "trap";    default: return "rst_midmem";
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.i_type = m_itype;
    return o;
  endfunction

  function automatic outs_t no_itype();
    outs_t m;
    m = '1;
    m.i_type = 3'd0;
    return m;
  endfunction

  task automatic push(input logic mr, input logic bt, input outs_t e, input outs_t m, input int ph);
    step_t s;
    s.mr = mr; s.bt = bt; s.exp = e; s.msk = m; s.ph = ph; s.idx = n_instr;
    q.push_back(s);
  endtask

  task automatic run_steps(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      mem_ready    = s.mr;
      branch_taken = s.bt;
      #1;
      check($sformatf("%s#%0d", pname(s.ph), s.idx), 32'(w_obs & s.msk), 32'(s.exp & s.msk));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int ph, input int n);
    outs_t e;
    e = '0;
    e.i_type = 3'd7;
    reset = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      check(pname(ph), 32'(w_obs), 32'(e));
    end
    reset   = 1'b0;
    m_itype = 3'd7;
    q.delete();
    push(1'b1, 1'b0, e, '1, P_IDLE);
  endtask

  // Expected trace of one instruction derived from its encoding.
  task automatic plan_instr(input logic [31:0] ins, input logic bt, input int fwait, input int mwait);
    outs_t e;
    logic [2:0] it;
    logic [1:0] wb, ps;
    logic asel, bsel, ill, is_ld, is_st, is_br;
    n_instr++;
    instr = ins;
    it = 3'd7; wb = 2'd0; ps = 2'd0; asel = 1'b0; bsel = 1'b1;
    ill = 1'b0; is_ld = 1'b0; is_st = 1'b0; is_br = 1'b0;
    case (ins[6:0])
      7'b0110011: begin it = 3'd7; bsel = 1'b0; end
      7'b0010011: it = 3'd0;
      7'b0000011: begin it = 3'd0; wb = 2'd1; is_ld = 1'b1; end
      7'b0100011: begin it = 3'd1; is_st = 1'b1; end
      7'b1100011: begin it = 3'd2; bsel = 1'b0; is_br = 1'b1; end
      7'b0110111: begin it = 3'd3; wb = 2'd3; end
      7'b0010111: begin it = 3'd3; asel = 1'b1; end
      7'b1101111: begin it = 3'd4; wb = 2'd2; ps = 2'd1; end
      7'b1100111: begin it = 3'd0; wb = 2'd2; ps = 2'd2; ill = (ins[14:12] != 3'b000); end
      default:    ill = 1'b1;
    endcase
    for (int i = 0; i < fwait; i++) begin
      e = base(); e.mem_req = 1'b1;
      push(1'b0, 1'b0, e, '1, P_FWAIT);
    end
    e = base(); e.mem_req = 1'b1; e.ir_write = 1'b1;
    push(1'b1, 1'b0, e, '1, P_FETCH);
    if (ill) begin
      push(1'b0, 1'b0, '0, no_itype(), P_DEC);
      e = '0; e.illegal = 1'b1;
      for (int i = 0; i < 20; i++) push(1'b1, 1'b1, e, no_itype(), P_TRAP);
      return;
    end
    m_itype = it;
    push(1'b0, 1'b0, base(), '1, P_DEC);
    e = base(); e.alu_a = asel; e.alu_b = bsel;
    if (is_br) begin
      e.pc_write = 1'b1; e.retire = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0;
    end
    push(1'b0, bt, e, '1, P_EXEC);
    if (is_ld || is_st) begin
      for (int i = 0; i < mwait; i++) begin
        e = base(); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = is_st;
        push(1'b0, 1'b0, e, '1, P_MWAIT);
      end
      e = base(); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = is_st;
      e.pc_write = is_st; e.retire = is_st;
      push(1'b1, 1'b0, e, '1, P_MEM);
    end
    if (!is_br && !is_st) begin
      e = base(); e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
      e.wb_sel = wb; e.pc_src = ps;
      push(1'b0, 1'b0, e, '1, P_WB);
    end
  endtask

  task automatic plan_timeout();
    outs_t e;
    n_instr++;
    for (int i = 0; i < TIMEOUT_CYCLES; i++) begin
      e = base(); e.mem_req = 1'b1;
      push(1'b0, 1'b0, e, '1, P_FWAIT);
    end
    e = base(); e.bus_err = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0, e, '1, P_TRAP);
  endtask

  initial begin
    do_reset(P_RESET, 3);
    plan_instr(32'h00A00093, 1'b0, 0, 0); run_steps(100);  // addi
    plan_instr(32'h00208463, 1'b1, 0, 0); run_steps(100);  // beq taken
    plan_instr(32'h00208463, 1'b0, 0, 0); run_steps(100);  // beq not taken
    plan_instr(32'h0000A103, 1'b0, 0, 3); run_steps(100);  // lw, 3 wait states
    plan_instr(32'h0020A023, 1'b0, 0, 1); run_steps(100);  // sw
    plan_instr(32'h123450B7, 1'b0, 0, 0); run_steps(100);  // lui
    plan_instr(32'h008000EF, 1'b0, 0, 0); run_steps(100);  // jal
    plan_instr(32'h000080E7, 1'b0, 0, 0); run_steps(100);  // jalr
    plan_instr(32'h002081B3, 1'b0, 1, 0); run_steps(100);  // add
    plan_instr(32'h00000097, 1'b0, 0, 0); run_steps(100);  // auipc
    plan_instr(32'h0000A103, 1'b0, TIMEOUT_CYCLES - 1, 0); run_steps(100);
    plan_instr(32'h000090E7, 1'b0, 0, 0); run_steps(100);  // jalr funct3=1
    do_reset(P_RESET, 1);
    plan_instr(32'hFFFFFFFF, 1'b0, 0, 0); run_steps(100);
    do_reset(P_RESET, 2);
    plan_instr(32'h00A00093, 1'b0, 0, 0); run_steps(100);
    plan_timeout(); run_steps(100);
    do_reset(P_RESET, 1);
    plan_instr(32'h0000A103, 1'b0, 0, 4); run_steps(5);     // stop in MEM wait
    do_reset(P_RSTMID, 1);
    plan_instr(32'h0020A023, 1'b0, 0, 0); run_steps(100);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the immediate-type select consumed by the immediate generator, plus all datapath mux selects, write enables and the memory request handshake.
- Detects illegal opcodes and memory timeouts and parks the core in a trap state.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles for mem_ready in FETCH/MEM before bus error; 0 disables timeout
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory completes the current request this cycle
branch_taken  in  1  ALU compare result, valid in EXEC
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  request is a write (store)
addr_sel  out  1  memory address: 0=PC, 1=ALU result
ir_write  out  1  load instr register from memory read data
pc_write  out  1  update PC this cycle
pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result&~1
i_type  out  3  immediate select: 0=I, 1=S, 2=B, 3=U, 4=J, 7=none (R-type)
alu_a_sel  out  1  0=rs1, 1=PC
alu_b_sel  out  1  0=rs2, 1=immediate
reg_write  out  1  write rd this cycle
wb_sel  out  2  0=ALU, 1=load data, 2=PC+4, 3=immediate
retire  out  1  one-cycle pulse on an instruction's final cycle
illegal  out  1  sticky: illegal instruction trapped
bus_err  out  1  sticky: memory timeout trapped

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset:
  - While reset is high, state goes to IDLE and the wait counter and sticky flags clear.
  - All outputs are 0 in IDLE, except i_type=7.
  - IDLE goes to FETCH unconditionally on the first cycle with reset low.
  - Reset asserted in any state, including mid-request, returns to IDLE on the next edge.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready: ir_write=1 for that cycle and go to DECODE.
  - mem_ready can complete in the first FETCH cycle (zero-wait).
- DECODE (one cycle):
  - Classify instr[6:0]; i_type is valid from DECODE through the instruction's last cycle, then held until the next DECODE.
  - Opcode to i_type: OP 0110011 gives 7. OP-IMM 0010011, LOAD 0000011 and JALR 1100111 give 0. STORE 0100011 gives 1. BRANCH 1100011 gives 2. LUI 0110111 and AUIPC 0010111 give 3. JAL 1101111 gives 4.
  - Any other opcode, or JALR with funct3!=0, goes to TRAP with illegal=1.
- EXEC:
  - alu_b_sel=1 for all types except OP and BRANCH.
  - alu_a_sel=1 for AUIPC.
  - BRANCH: pc_write=1, pc_src=branch_taken?1:0, retire=1, then FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=1 for STORE.
  - On mem_ready: LOAD goes to WB; STORE pulses pc_write (pc_src=0) and retire, then FETCH.
- WB:
  - reg_write=1 and pc_write=1, then retire and FETCH.
  - wb_sel: 0 for OP, OP-IMM and AUIPC; 1 for LOAD; 2 for JAL and JALR; 3 for LUI.
  - pc_src: 1 for JAL, 2 for JALR, else 0.
- Sequencing rules:
  - pc_write and retire assert exactly once per retired instruction, in the same cycle.
  - Zero-wait latency: BRANCH 3 cycles; STORE, ALU, LUI/AUIPC and jumps 4; LOAD 5.
- Timeout:
  - The counter increments each FETCH/MEM cycle without mem_ready and clears on mem_ready or on a state change.
  - When TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1 without mem_ready, go to TRAP with bus_err=1; mem_req deasserts in TRAP.
  - mem_ready arriving in the same cycle as the limit wins: no error.
- TRAP:
  - All strobes are 0; illegal and bus_err hold.
  - Only reset exits TRAP.

Test Plan:
- reset 3 cycles, mem_ready=1, instr=0x00A00093 (addi x1,x0,10) -> IDLE for 1 cycle; then FETCH/DECODE/EXEC/WB; i_type=0, alu_b_sel=1, wb_sel=0; reg_write, pc_write and retire pulse in cycle 4 only.
- instr=0x00208463 (beq), branch_taken=1 then 0 on a rerun -> i_type=2; pc_src=1 (then 0) with pc_write and retire in EXEC; 3-cycle latency; reg_write never 1.
- LOAD 0x0000A103 with mem_ready low 3 cycles in MEM -> mem_req=1, addr_sel=1 held 3 cycles; WB has wb_sel=1; 8 cycles total. STORE 0x0020A023 -> i_type=1, mem_we=1 in MEM, no reg_write.
- LUI 0x123450B7 -> i_type=3, wb_sel=3. JAL 0x008000EF -> i_type=4, wb_sel=2, pc_src=1. JALR 0x000080E7 -> pc_src=2. JALR with funct3=1 -> illegal=1, TRAP.
- instr=0xFFFFFFFF -> TRAP after DECODE, illegal=1; strobes stay 0 for 20 cycles; reset -> illegal=0, FETCH after IDLE.
- TIMEOUT_CYCLES=4, mem_ready=0 in FETCH -> bus_err=1 after exactly 4 FETCH cycles. Rerun with mem_ready on the 4th cycle -> DECODE, no bus_err. Reset mid-MEM -> IDLE next edge, mem_req=0.
